// File: rtl/beep_sequencer.sv
// beep_sequencer: arbitrates the single board buzzer between three event
// sources (key click, timer expiry, alarm). Each source has a fixed pattern
// of N beeps, each ON ms low followed by OFF ms high. One request per source
// is queued. Patterns play one at a time, highest source index first, with no
// preemption.
//
// Optional feature: define BEEP_TONE_EN for a passive buzzer. beep then
// toggles every TONE_DIV cycles during ON instead of being held low.
//
// Request semantics: req[i] is a level sampled on every sys_clk edge, with no
// handshake. A high sample sets pending[i]. A sample that coincides with the
// grant of the same source keeps the bit set. While mute is high, every
// request is dropped.
module beep_sequencer #(
  parameter int MS_DIV   = 50000,
  parameter int ON0      = 50,
  parameter int OFF0     = 50,
  parameter int N0       = 1,
  parameter int ON1      = 100,
  parameter int OFF1     = 100,
  parameter int N1       = 2,
  parameter int ON2      = 200,
  parameter int OFF2     = 200,
  parameter int N2       = 5,
  parameter int TONE_DIV = 12500
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [2:0] req,
  input  logic       mute,
  output logic       beep,
  output logic       busy,
  output logic [1:0] active_src
);

  localparam int PW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(MS_DIV - 1);

  // Reject parameter sets whose counters could wrap.
  if (MS_DIV < 1 || TONE_DIV < 1) begin : g_bad_div
    $error("beep_sequencer: MS_DIV and TONE_DIV must be >= 1");
  end
  if (ON0 < 1 || ON0 > 255 || OFF0 < 1 || OFF0 > 255 || N0 < 1 || N0 > 7 ||
      ON1 < 1 || ON1 > 255 || OFF1 < 1 || OFF1 > 255 || N1 < 1 || N1 > 7 ||
      ON2 < 1 || ON2 > 255 || OFF2 < 1 || OFF2 > 255 || N2 < 1 || N2 > 7)
  begin : g_bad_pattern
    $error("beep_sequencer: pattern parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    pend_q, pend_d;
  logic [1:0]    src_q, src_d;
  logic [2:0]    rep_q, rep_d;
  logic [7:0]    dur_q, dur_d;
  logic [PW-1:0] presc_q, presc_d;

  logic [1:0] grant_src;
  logic [2:0] grant_clr;
  logic [7:0] grant_on, grant_n_on, cur_on, cur_off;
  logic [2:0] grant_n;

  // Highest-index pending source and its pattern constants.
  always_comb begin
    grant_src = 2'd0;
    grant_clr = 3'b001;
    if (pend_q[2]) begin
      grant_src = 2'd2;
      grant_clr = 3'b100;
    end else if (pend_q[1]) begin
      grant_src = 2'd1;
      grant_clr = 3'b010;
    end
    grant_on   = 8'(ON0);
    grant_n_on = 8'(N0);
    case (grant_src)
      2'd1:    begin grant_on = 8'(ON1); grant_n_on = 8'(N1); end
      2'd2:    begin grant_on = 8'(ON2); grant_n_on = 8'(N2); end
      default: begin grant_on = 8'(ON0); grant_n_on = 8'(N0); end
    endcase
    grant_n = grant_n_on[2:0];
  end

  // On/off durations of the source currently playing.
  always_comb begin
    cur_on  = 8'(ON0);
    cur_off = 8'(OFF0);
    case (src_q)
      2'd1:    begin cur_on = 8'(ON1); cur_off = 8'(OFF1); end
      2'd2:    begin cur_on = 8'(ON2); cur_off = 8'(OFF2); end
      default: begin cur_on = 8'(ON0); cur_off = 8'(OFF0); end
    endcase
  end

  // Next-state logic: pending latch, grant, and ON/OFF phase timing.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    src_d   = src_q;
    rep_d   = rep_q;
    dur_d   = dur_q;
    presc_d = presc_q;
    if (mute) begin
      state_d = ST_IDLE;
      pend_d  = 3'b000;
      src_d   = 2'd3;
      rep_d   = 3'd0;
      dur_d   = 8'd0;
      presc_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pend_q != 3'b000) begin
            state_d = ST_ON;
            src_d   = grant_src;
            pend_d  = pend_q & ~grant_clr;
            rep_d   = grant_n;
            dur_d   = grant_on;
            presc_d = '0;
          end
        end
        ST_ON: begin
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (dur_q == 8'd1) begin
              state_d = ST_OFF;
              dur_d   = cur_off;
              rep_d   = rep_q - 3'd1;
            end else begin
              dur_d = dur_q - 8'd1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        ST_OFF: begin
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (dur_q == 8'd1) begin
              if (rep_q != 3'd0) begin
                state_d = ST_ON;
                dur_d   = cur_on;
              end else begin
                state_d = ST_IDLE;
                src_d   = 2'd3;
                dur_d   = 8'd0;
              end
            end else begin
              dur_d = dur_q - 8'd1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          src_d   = 2'd3;
        end
      endcase
      // A new request wins over the grant clearing the same bit.
      pend_d = pend_d | req;
    end
  end

  // State and counter registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= 3'b000;
      src_q   <= 2'd3;
      rep_q   <= 3'd0;
      dur_q   <= 8'd0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      src_q   <= src_d;
      rep_q   <= rep_d;
      dur_q   <= dur_d;
      presc_q <= presc_d;
    end
  end

  assign busy       = (state_q == ST_ON) || (state_q == ST_OFF);
  assign active_src = src_q;

`ifdef BEEP_TONE_EN
  localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);

  logic [TW-1:0] tone_cnt_q, tone_cnt_d;
  logic          tone_lvl_q, tone_lvl_d;

  // Tone divider: restarts low on every ON entry and toggles every TONE_DIV cycles.
  always_comb begin
    tone_cnt_d = tone_cnt_q;
    tone_lvl_d = tone_lvl_q;
    if (state_d == ST_ON && state_q != ST_ON) begin
      tone_cnt_d = '0;
      tone_lvl_d = 1'b0;
    end else if (state_q == ST_ON) begin
      if (tone_cnt_q == TONE_LAST) begin
        tone_cnt_d = '0;
        tone_lvl_d = ~tone_lvl_q;
      end else begin
        tone_cnt_d = tone_cnt_q + TW'(1);
      end
    end
  end

  // Tone divider registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tone_cnt_q <= '0;
      tone_lvl_q <= 1'b0;
    end else begin
      tone_cnt_q <= tone_cnt_d;
      tone_lvl_q <= tone_lvl_d;
    end
  end

  assign beep = (state_q == ST_ON) ? tone_lvl_q : 1'b1;
`else
  assign beep = (state_q != ST_ON);
`endif

endmodule

// File: doc/beep_sequencer.md
Name: beep_sequencer

Overview:
Shares the single board buzzer between three event sources: key click, timer expiry and alarm. Each source has a fixed beep pattern: beep count, on-time and off-time in ms. The block arbitrates by fixed priority, queues one pending request per source and plays patterns one at a time. It sits between the key/timer logic and the beep pin, replacing direct toggling of the pin.

Parameters:
MS_DIV, 50000, sys_clk cycles per 1 ms tick (50 MHz clock).
ON0, 50, source 0 (key click) on-time in ms, range 1..255.
OFF0, 50, source 0 off-time in ms, range 1..255.
N0, 1, source 0 beep count, range 1..7.
ON1, 100, source 1 (timer) on-time in ms.
OFF1, 100, source 1 off-time in ms.
N1, 2, source 1 beep count.
ON2, 200, source 2 (alarm) on-time in ms.
OFF2, 200, source 2 off-time in ms.
N2, 5, source 2 beep count.
TONE_DIV, 12500, half-period in cycles of the passive-buzzer tone (used only with the optional feature).

Ports:
sys_clk  input  1  system clock.
sys_rst_n  input  1  reset, asynchronous, active-low; clock sys_clk.
req  input  3  per-source request pulses, synchronous to sys_clk; req[2] = alarm, req[1] = timer, req[0] = key.
mute  input  1  level; aborts playback and blocks/clears all requests while high.
beep  output  1  buzzer drive, active-low (0 = sounding).
busy  output  1  high while a pattern is playing (state ON or OFF).
active_src  output  2  index of the source being played; 2'd3 when idle.

Behaviour:
- Reset values: beep=1, busy=0, active_src=3, pending=000, state=IDLE, all counters 0.
- Pending latch:
  - req[i] high at an edge sets pending[i].
  - A req that coincides with the clear of its own pending bit wins; the bit stays set.
  - A re-request from the source currently playing sets pending and replays after the current pattern ends.
  - Multiple pulses while pending collapse to one play.
- State IDLE:
  - If mute=0 and pending!=0, grant the highest index pending source (2 > 1 > 0).
  - On grant: clear its pending bit, load rep=N, dur=ON, reset the ms prescaler; next state ON.
  - Latency: req sampled at edge k, idle block -> beep=0, busy=1, active_src valid from edge k+1.
- State ON:
  - beep=0.
  - Lasts exactly ON*MS_DIV cycles (prescaler counts 0..MS_DIV-1; dur decrements on wrap).
  - Then go to OFF, load dur=OFF, decrement rep.
- State OFF:
  - beep=1.
  - Lasts exactly OFF*MS_DIV cycles.
  - Then go to ON if rep!=0, else IDLE.
  - The trailing OFF gap is always played, so back-to-back patterns are separated by at least OFF ms.
- No preemption: a higher-priority request arriving mid-pattern waits until the current pattern reaches IDLE.
- mute=1 (any state):
  - At the next edge: state=IDLE, beep=1, busy=0, active_src=3, pending=000.
  - req is ignored while mute is high.
- Counter widths:
  - Prescaler: clog2(MS_DIV) bits.
  - dur: 8 bits.
  - rep: 3 bits.
  - No wrap is possible within the legal parameter ranges.
- Reset asserted mid-pattern returns all outputs to their reset values immediately (asynchronous).

Optional Feature:
Macro BEEP_TONE_EN, for a passive buzzer.
- Defined: during ON, beep toggles every TONE_DIV cycles, starting at 0 on ON entry; the tone divider resets on each ON entry. beep=1 in IDLE and OFF.
- Undefined: beep is held at 0 for the whole ON phase (active buzzer); no tone divider is synthesised.

Test Plan:
- All tests use MS_DIV=10.
- Key click: 1-cycle req[0] pulse at edge k -> beep=0 from edge k+1 for 500 cycles, then beep=1 for 500 cycles, then IDLE; busy high for 1000 cycles; active_src=0.
- Alarm pattern: req[2] pulse -> 5 low pulses of 2000 cycles, separated by 2000 cycles high; total busy time 20000 cycles; active_src=2.
- Priority: req[0] and req[1] pulsed in the same cycle -> source 1 plays first (2 beeps), then source 0 (1 beep); IDLE lasts exactly 1 cycle between the two patterns.
- Queueing: req[0] pulsed 3 times during an alarm playback -> after the alarm, exactly one key-click pattern plays.
- Mute: mute raised during the 3rd alarm beep with req[1] pending -> next edge beep=1, busy=0, active_src=3; after mute drops, no pattern plays.
- Reset: sys_rst_n pulsed low mid-ON -> beep=1 immediately; after release, no pattern resumes. With BEEP_TONE_EN and TONE_DIV=4 -> beep toggles every 4 cycles during ON.
